// File: rtl/mag_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : mag_bcd_conv
// Purpose  : Takes a WIDTH-bit operand (two's complement or unsigned),
//            registers its magnitude and sign, then converts the magnitude
//            to packed BCD with a one-bit-per-cycle double-dabble FSM.
//            Valid/ready handshakes on both the operand and result sides.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        operand width in bits (>= 2)
//   DIGITS       BCD output digits; 10**DIGITS must be >= 2**WIDTH
// Ports
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   IN_VALID     operand valid
//   IN_READY     block can accept an operand (high only in IDLE)
//   INPUT        operand
//   SIGNED_MODE  1: INPUT is two's complement, 0: unsigned
//   OUT_VALID    result valid (high only in DONE)
//   OUT_READY    consumer accepts the result
//   MAG_RESULT   unsigned magnitude of the accepted operand
//   NEG_FLAG     accepted operand was negative
//   BCD_RESULT   packed BCD of the magnitude, digit 0 in bits [3:0]
//   BUSY         FSM not in IDLE
// Build options
//   MAG_BCD_BLANK_EN  when defined, zero digits above the most significant
//                     non-zero digit are replaced by 4'hF at result load.
//                     Digit 0 is never blanked.
// ============================================================================
module mag_bcd_conv #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [WIDTH-1:0]      INPUT,
    input  logic                  SIGNED_MODE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [WIDTH-1:0]      MAG_RESULT,
    output logic                  NEG_FLAG,
    output logic [4*DIGITS-1:0]   BCD_RESULT,
    output logic                  BUSY
);

    localparam int BCD_W = 4 * DIGITS;
    // Counter only has to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    function automatic bit f_digits_ok(input int w, input int d);
        longint unsigned p10;
        longint unsigned p2;
        p10 = 64'd1;
        p2  = 64'd1 << w;
        for (int i = 0; i < d; i++) begin
            if (p10 >= p2) begin
                return 1'b1;
            end
            p10 = p10 * 64'd10;
        end
        return (p10 >= p2);
    endfunction

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("mag_bcd_conv: WIDTH must be at least 2");
        end
        if (!f_digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
            $error("mag_bcd_conv: DIGITS too small, need 10**DIGITS >= 2**WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_q,   mag_d;
    logic                 neg_q,   neg_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BCD_W-1:0]     acc_q,   acc_d;
    logic [BCD_W-1:0]     bcd_q,   bcd_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    // ------------------------------------------------------------------------
    // Operand magnitude. The most-negative value maps onto itself, which read
    // as unsigned is exactly 2**(WIDTH-1), so no saturation is needed.
    // ------------------------------------------------------------------------
    logic                 w_is_neg;
    logic [WIDTH-1:0]     w_in_mag;

    assign w_is_neg = SIGNED_MODE & INPUT[WIDTH-1];
    assign w_in_mag = w_is_neg ? WIDTH'(~INPUT + WIDTH'(1)) : INPUT;

    // ------------------------------------------------------------------------
    // Double-dabble step: add 3 to every digit >= 5, then shift the
    // {accumulator, shift register} pair left by one.
    // ------------------------------------------------------------------------
    logic [BCD_W-1:0]     w_acc_adj;
    logic [BCD_W-1:0]     w_acc_shl;
    logic [BCD_W-1:0]     w_bcd_final;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign w_acc_adj[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5)
                                       ? (acc_q[4*g +: 4] + 4'd3)
                                       : acc_q[4*g +: 4];
        end
    endgenerate

    assign w_acc_shl = {w_acc_adj[BCD_W-2:0], shift_q[WIDTH-1]};

`ifdef MAG_BCD_BLANK_EN
    // Scan from the top digit down; while only zeros have been seen, replace
    // them with the blank code. Digit 0 stays as-is so zero displays as 0.
    logic w_lead;

    always_comb begin
        w_bcd_final = w_acc_shl;
        w_lead      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (w_acc_shl[4*i +: 4] == 4'd0)) begin
                w_bcd_final[4*i +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_bcd_final = w_acc_shl;
`endif

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b1;

        case (state_q)
            S_IDLE: begin
                IN_READY = 1'b1;
                BUSY     = 1'b0;
                if (IN_VALID) begin
                    mag_d   = w_in_mag;
                    neg_d   = w_is_neg;
                    shift_d = w_in_mag;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                acc_d   = w_acc_shl;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                // WIDTH-th shift: the shifted accumulator is the final value.
                if (cnt_q == c_last_cnt) begin
                    bcd_d   = w_bcd_final;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            shift_q <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign MAG_RESULT = mag_q;
    assign NEG_FLAG   = neg_q;
    assign BCD_RESULT = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mag_bcd_conv
// Purpose  : Directed self-checking bench for mag_bcd_conv (WIDTH=6,
//            DIGITS=2). Expected values are hand-computed constants; the
//            blanked variants apply when MAG_BCD_BLANK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mag_bcd_conv;

    localparam int W = 6;
    localparam int D = 2;
`ifdef MAG_BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic           CLK;
    logic           RESET_N;
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   INPUT;
    logic           SIGNED_MODE;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [W-1:0]   MAG_RESULT;
    logic           NEG_FLAG;
    logic [4*D-1:0] BCD_RESULT;
    logic           BUSY;

    int n_cmp = 0;
    int n_err = 0;

    mag_bcd_conv #(.WIDTH(W), .DIGITS(D)) u_dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .INPUT       (INPUT),
        .SIGNED_MODE (SIGNED_MODE),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .MAG_RESULT  (MAG_RESULT),
        .NEG_FLAG    (NEG_FLAG),
        .BCD_RESULT  (BCD_RESULT),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bx(input logic [7:0] plain, input logic [7:0] blanked);
        return BLANK ? blanked : plain;
    endfunction

    // Present an operand at a falling edge; it is taken on the next rising edge.
    task automatic accept(input logic [W-1:0] val, input logic smode);
        @(negedge CLK);
        IN_VALID    = 1'b1;
        INPUT       = val;
        SIGNED_MODE = smode;
        check("in_ready_before_accept", IN_READY, 1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID    = 1'b0;
        INPUT       = ~val;
        SIGNED_MODE = ~smode;
        check("busy_after_accept", BUSY, 1);
    endtask

    // Entered at the falling edge after acceptance. Edges are counted with the
    // acceptance edge itself as edge 1; OUT_VALID must be seen after edge W+1.
    task automatic wait_result(input string tag, input logic [W-1:0] e_mag,
                               input logic e_neg, input logic [7:0] e_bcd);
        int edges = 1;
        while (!OUT_VALID && edges < 40) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        check({tag, "_latency"}, edges, W + 1);
        check({tag, "_mag"}, MAG_RESULT, e_mag);
        check({tag, "_neg"}, NEG_FLAG, e_neg);
        check({tag, "_bcd"}, BCD_RESULT, e_bcd);
        check({tag, "_in_ready_done"}, IN_READY, 0);
    endtask

    task automatic release_result();
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("out_valid_after_release", OUT_VALID, 0);
        check("in_ready_after_release", IN_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N     = 1'b1;
        IN_VALID    = 1'b0;
        INPUT       = '0;
        SIGNED_MODE = 1'b0;
        OUT_READY   = 1'b0;

        // Reset asserted mid-cycle, checked before the first rising edge.
        #2 RESET_N = 1'b0;
        #1;
        check("rst_in_ready", IN_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_mag", MAG_RESULT, 0);
        check("rst_neg", NEG_FLAG, 0);
        check("rst_bcd", BCD_RESULT, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("post_rst_in_ready", IN_READY, 1);

        // -5 signed
        accept(6'b111011, 1'b1);
        wait_result("neg5", 6'd5, 1'b1, bx(8'h05, 8'hF5));
        release_result();

        // most-negative signed value
        accept(6'b100000, 1'b1);
        wait_result("neg32", 6'd32, 1'b1, 8'h32);
        release_result();

        // unsigned all-ones
        accept(6'b111111, 1'b0);
        wait_result("u63", 6'd63, 1'b0, 8'h63);
        release_result();

        // positive signed
        accept(6'b011001, 1'b1);
        wait_result("pos25", 6'd25, 1'b0, 8'h25);

        // Backpressure in DONE with a competing operand on the input side.
        IN_VALID    = 1'b1;
        INPUT       = 6'd9;
        SIGNED_MODE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("bp_out_valid", OUT_VALID, 1);
            check("bp_in_ready", IN_READY, 0);
            check("bp_mag", MAG_RESULT, 25);
            check("bp_neg", NEG_FLAG, 0);
            check("bp_bcd", BCD_RESULT, 8'h25);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("bp_release_out_valid", OUT_VALID, 0);
        check("bp_release_in_ready", IN_READY, 1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        INPUT    = 6'd0;
        check("bp_accept_busy", BUSY, 1);
        wait_result("u9", 6'd9, 1'b0, bx(8'h09, 8'hF9));
        release_result();

        // Reset mid-SHIFT once three shifts have completed.
        accept(6'b101111, 1'b1);
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_in_ready", IN_READY, 1);
        check("mid_rst_out_valid", OUT_VALID, 0);
        check("mid_rst_mag", MAG_RESULT, 0);
        check("mid_rst_neg", NEG_FLAG, 0);
        check("mid_rst_bcd", BCD_RESULT, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        accept(6'b101111, 1'b1);
        wait_result("neg17", 6'd17, 1'b1, 8'h17);
        release_result();

        // Leading-zero cases
        accept(6'd7, 1'b0);
        wait_result("u7", 6'd7, 1'b0, bx(8'h07, 8'hF7));
        release_result();

        accept(6'd0, 1'b0);
        wait_result("u0", 6'd0, 1'b0, bx(8'h00, 8'hF0));
        release_result();

        accept(6'd40, 1'b0);
        wait_result("u40", 6'd40, 1'b0, 8'h40);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mag_bcd_conv.md
Name: mag_bcd_conv

Overview:
Parametrised successor to the ALU magnitude/sign stage. It takes a WIDTH-bit operand, either two's complement or unsigned, and registers its magnitude and sign. It then converts the magnitude to packed BCD with a multi-cycle double-dabble FSM for the seven-segment display path. Valid/ready handshakes sit on both sides, so the block fits between the ALU result register and the display driver.

Parameters:
WIDTH, 6, operand width in bits (>= 2).
DIGITS, 2, number of BCD output digits. Must satisfy 10^DIGITS >= 2^WIDTH; elaboration error otherwise.

Ports:
CLK  input  1  system clock, rising edge.
RESET_N  input  1  asynchronous, active-low reset.
IN_VALID  input  1  INPUT/SIGNED_MODE valid.
IN_READY  output  1  block can accept an operand.
INPUT  input  WIDTH  operand.
SIGNED_MODE  input  1  1: INPUT is two's complement; 0: unsigned.
OUT_VALID  output  1  MAG_RESULT/NEG_FLAG/BCD_RESULT valid.
OUT_READY  input  1  consumer accepts the result.
MAG_RESULT  output  WIDTH  unsigned magnitude.
NEG_FLAG  output  1  operand was negative.
BCD_RESULT  output  4*DIGITS  packed BCD of the magnitude; digit 0 in bits [3:0].
BUSY  output  1  FSM not in IDLE.

Behaviour:
- One clock domain: CLK. Reset is asynchronous and active-low on RESET_N.
- Reset values: all outputs 0 except IN_READY = 1. FSM goes to IDLE, shift counter 0, internal BCD/shift registers 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY = 1, BUSY = 0, OUT_VALID = 0.
  - Acceptance = IN_VALID & IN_READY at a rising edge.
  - On acceptance, register the magnitude and sign:
    - SIGNED_MODE = 1 and INPUT[WIDTH-1] = 1: MAG_RESULT = ~INPUT + 1 (modulo 2^WIDTH), NEG_FLAG = 1.
    - Otherwise: MAG_RESULT = INPUT, NEG_FLAG = 0.
  - Also load the shift register with the new magnitude, clear the BCD accumulator, set count = 0, go to SHIFT.
- Most-negative signed value (100...0): MAG_RESULT = 2^(WIDTH-1) read as unsigned, NEG_FLAG = 1. No saturation, no error.
- SHIFT, once per cycle:
  - Each BCD digit >= 5 gets +3.
  - Then shift {accumulator, shift register} left by 1; the MSB of the magnitude enters digit 0 LSB.
  - count increments. When count reaches WIDTH-1 on this edge, go to DONE and load BCD_RESULT with the final accumulator.
- Latency: OUT_VALID rises exactly WIDTH+1 rising edges after the acceptance edge, i.e. WIDTH cycles in SHIFT plus the transition.
- DONE:
  - OUT_VALID = 1, IN_READY = 0.
  - All outputs held stable while OUT_READY = 0, for any duration.
  - OUT_READY = 1 at an edge: return to IDLE, OUT_VALID = 0 next cycle.
  - No same-cycle re-accept; minimum initiation interval is WIDTH+2 cycles.
- MAG_RESULT and NEG_FLAG change only at acceptance. BCD_RESULT changes only on SHIFT->DONE. Values are retained in IDLE, but consumers must qualify them with OUT_VALID.
- IN_VALID outside IDLE is ignored. INPUT changes during SHIFT/DONE have no effect.
- SIGNED_MODE is sampled only at acceptance.
- OUT_READY in IDLE/SHIFT is ignored.
- RESET_N asserted in any state (including mid-SHIFT): immediate abort to reset values. No partial result is ever presented.
- BUSY = (state != IDLE).

Optional Feature:
Macro MAG_BCD_BLANK_EN.
- Defined: leading-zero blanking on BCD_RESULT at the SHIFT->DONE load. Every zero digit above the most significant non-zero digit becomes 4'hF (blank code). Digit 0 is never blanked, so a zero result shows 0.
- Not defined: BCD_RESULT is plain packed BCD with leading zeros. No blanking logic is synthesised.

Test Plan:
1. Assert RESET_N = 0 mid-cycle, release -> all outputs 0, IN_READY = 1, BUSY = 0. Reset response must be asynchronous (observed before the next CLK edge).
2. Signed mode, WIDTH = 6, INPUT = 6'b111011 (-5) -> MAG_RESULT = 5, NEG_FLAG = 1, BCD_RESULT = 8'h05. OUT_VALID rises exactly 7 edges after acceptance.
3. Signed 6'b100000 -> MAG_RESULT = 32, NEG_FLAG = 1, BCD = 8'h32. Unsigned 6'b111111 -> MAG = 63, NEG = 0, BCD = 8'h63. Signed 6'b011001 -> MAG = 25, NEG = 0, BCD = 8'h25.
4. Backpressure: hold OUT_READY = 0 for 10 cycles in DONE while driving IN_VALID = 1 with a new INPUT = 9. Required: outputs stable, IN_READY = 0, new operand ignored. Then OUT_READY = 1 -> IDLE next cycle, and operand 9 is accepted on the following edge with result 8'h09.
5. Reset mid-SHIFT (count = 3) -> outputs 0 and IDLE immediately. Next transaction (-17) -> MAG = 17, NEG = 1, BCD = 8'h17 with correct latency.
6. With MAG_BCD_BLANK_EN: unsigned 7 -> BCD 8'hF7; 0 -> 8'hF0; 40 -> 8'h40. Without the macro: 7 -> 8'h07, 0 -> 8'h00.
